// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM states, owner encodings and default wait states
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;
    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;
    localparam int unsigned WAIT_STATES_DEFAULT = 2;
endpackage

// File: rtl/wait_counter.sv
// wait_counter: loadable down-counter with zero flag timing the memory access
module wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic       zero
);
    logic [3:0] count;
    // load has priority; decrement saturates at zero
    always_ff @(posedge clk) begin
        if (rst) count <= 4'd0;
        else if (load) count <= load_val;
        else if (dec && count != 4'd0) count <= count - 4'd1;
    end
    assign zero = count == 4'd0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store
import mem_port_arbiter_pkg::*;
module mem_port_arbiter #(
    parameter int unsigned WAIT_STATES = WAIT_STATES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_be,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ready,
    output logic [31:0] ls_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    state_t      state, state_next;
    logic        owner, last_owner, gnt_ls, load, dec, zero, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    wait_counter u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .dec      (dec),
        .load_val (4'(WAIT_STATES)),
        .zero     (zero)
    );
    // arbitration (LS wins a tie unless it owned the previous access) and next state
    always_comb begin
        gnt_ls     = ls_req && (!if_req || last_owner == OWNER_IF);
        load       = state == IDLE && (if_req || ls_req);
        dec        = state == ACCESS && !zero;
        state_next = state == IDLE   ? (load ? ACCESS : IDLE) :
                     state == ACCESS ? (zero ? RESPOND : ACCESS) : IDLE;
    end
    // state register, request latches and per-requester read data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWNER_IF;
            last_owner <= OWNER_IF;
            addr       <= 32'h0;
            we         <= 1'b0;
            be         <= 4'h0;
            wdata      <= 32'h0;
            if_rdata   <= 32'h0;
            ls_rdata   <= 32'h0;
        end else begin
            state <= state_next;
            if (load) begin
                owner <= gnt_ls ? OWNER_LS : OWNER_IF;
                addr  <= gnt_ls ? ls_addr : if_addr;
                we    <= gnt_ls && ls_we;
                be    <= gnt_ls ? ls_be : 4'hF;
                wdata <= gnt_ls ? ls_wdata : 32'h0;
            end
            if (state == ACCESS && zero) begin
                last_owner <= owner;
                if (owner == OWNER_IF) if_rdata <= mem_rdata;
                else if (!we) ls_rdata <= mem_rdata;
            end
        end
    end
    assign mem_en    = state == ACCESS;
    assign mem_we    = mem_en && we;
    assign mem_be    = be;
    assign mem_addr  = addr;
    assign mem_wdata = wdata;
    assign if_ready  = state == RESPOND && owner == OWNER_IF;
    assign ls_ready  = state == RESPOND && owner == OWNER_LS;
    assign busy      = state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a queue scoreboard checked on every ready pulse
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [31:0] if_addr = 32'h0, ls_addr = 32'h0, ls_wdata = 32'h0;
    logic [3:0]  ls_be = 4'h0;
    logic        if_ready, ls_ready, mem_en, mem_we, busy;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        ls_req0 = 1'b0;
    logic        if_ready0, ls_ready0, mem_en0, mem_we0, busy0;
    logic [31:0] if_rdata0, ls_rdata0, mem_addr0, mem_wdata0;
    logic [31:0] mem_rdata0 = 32'h0;
    logic [3:0]  mem_be0;

    mem_port_arbiter #(.WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ready(ls_ready), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(1'b0), .if_addr(32'h0), .if_ready(if_ready0), .if_rdata(if_rdata0),
        .ls_req(ls_req0), .ls_we(1'b0), .ls_be(4'h0), .ls_addr(32'h40), .ls_wdata(32'h0),
        .ls_ready(ls_ready0), .ls_rdata(ls_rdata0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_be(mem_be0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .busy(busy0)
    );

    always #5 clk = ~clk;

    always_comb
        mem_rdata = mem_addr == 32'h100 ? 32'hE3A00001 :
                    mem_addr == 32'h300 ? 32'h12345678 :
                    mem_addr == 32'h104 ? 32'hCAFEF00D : 32'h0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic        ls;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic at(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg(input int t);
        at(t);
        @(negedge clk);
    endtask

    task automatic push(input logic ls, input logic [31:0] rdata, input int c);
        exp_t x;
        x.ls = ls;
        x.rdata = rdata;
        x.cyc = c;
        sb.push_back(x);
    endtask

    // monitor: every ready pulse must match the oldest expected completion
    always @(negedge clk) begin
        if (if_ready || ls_ready) begin
            if (sb.size() == 0) check("unexpected_ready", {30'h0, if_ready, ls_ready}, 32'h0);
            else begin
                e = sb.pop_front();
                check("ready_owner", {31'h0, ls_ready}, {31'h0, e.ls});
                check("single_ready", {31'h0, if_ready && ls_ready}, 32'h0);
                check("ready_rdata", e.ls ? ls_rdata : if_rdata, e.rdata);
                check("ready_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int c0;
        at_neg(2);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_mem_en", {31'h0, mem_en}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_if_ready", {31'h0, if_ready}, 32'h0);
        check("rst_ls_ready", {31'h0, ls_ready}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_ls_rdata", ls_rdata, 32'h0);
        at(3);
        rst = 1'b0;
        at(5);
        c0 = cyc;
        if_addr = 32'h100;
        ls_addr = 32'h300;
        if_req = 1'b1;
        ls_req = 1'b1;
        push(1'b1, 32'h12345678, c0 + 4);
        push(1'b0, 32'hE3A00001, c0 + 9);
        at(c0 + 5);
        ls_req = 1'b0;
        at(c0 + 10);
        if_req = 1'b0;
        at(c0 + 12);
        c0 = cyc;
        if_req = 1'b1;
        push(1'b0, 32'hE3A00001, c0 + 4);
        for (int k = 1; k <= 3; k++) begin
            at_neg(c0 + k);
            check("fetch_mem_en", {31'h0, mem_en}, 32'h1);
            check("fetch_mem_addr", mem_addr, 32'h100);
            check("fetch_mem_be", {28'h0, mem_be}, 32'hF);
            check("fetch_mem_we", {31'h0, mem_we}, 32'h0);
        end
        at_neg(c0 + 4);
        check("respond_mem_en", {31'h0, mem_en}, 32'h0);
        check("respond_busy", {31'h0, busy}, 32'h1);
        at(c0 + 5);
        if_req = 1'b0;
        at(c0 + 7);
        c0 = cyc;
        ls_we = 1'b1;
        ls_addr = 32'h200;
        ls_be = 4'b0011;
        ls_wdata = 32'hDEADBEEF;
        ls_req = 1'b1;
        push(1'b1, 32'h12345678, c0 + 4);
        for (int k = 1; k <= 3; k++) begin
            at_neg(c0 + k);
            check("store_mem_we", {31'h0, mem_we}, 32'h1);
            check("store_mem_addr", mem_addr, 32'h200);
            check("store_mem_be", {28'h0, mem_be}, 32'h3);
            check("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
        end
        at(c0 + 5);
        ls_req = 1'b0;
        ls_we = 1'b0;
        ls_addr = 32'h300;
        ls_be = 4'h0;
        at(c0 + 7);
        c0 = cyc;
        if_addr = 32'h100;
        if_req = 1'b1;
        ls_req = 1'b1;
        push(1'b0, 32'hE3A00001, c0 + 4);
        push(1'b1, 32'h12345678, c0 + 9);
        push(1'b0, 32'hE3A00001, c0 + 14);
        push(1'b1, 32'h12345678, c0 + 19);
        at(c0 + 20);
        if_req = 1'b0;
        ls_req = 1'b0;
        at(c0 + 22);
        c0 = cyc;
        if_addr = 32'h104;
        if_req = 1'b1;
        push(1'b0, 32'hCAFEF00D, c0 + 4);
        at(c0 + 1);
        if_req = 1'b0;
        at(c0 + 7);
        c0 = cyc;
        ls_addr = 32'h100;
        ls_req = 1'b1;
        at(c0 + 2);
        rst = 1'b1;
        ls_req = 1'b0;
        at_neg(c0 + 3);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_mem_en", {31'h0, mem_en}, 32'h0);
        check("abort_mem_we", {31'h0, mem_we}, 32'h0);
        check("abort_ls_ready", {31'h0, ls_ready}, 32'h0);
        check("abort_if_ready", {31'h0, if_ready}, 32'h0);
        check("abort_ls_rdata", ls_rdata, 32'h0);
        check("abort_if_rdata", if_rdata, 32'h0);
        rst = 1'b0;
        at(c0 + 8);
        c0 = cyc;
        ls_req0 = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            at_neg(c0 + k);
            check("ws0_ls_ready", {31'h0, ls_ready0}, {31'h0, k % 3 == 2});
            check("ws0_busy", {31'h0, busy0}, {31'h0, k % 3 != 0});
        end
        at(c0 + 9);
        ls_req0 = 1'b0;
        at(c0 + 11);
        check("scoreboard_empty", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
